alu_wide_sequencer: RTL and testbench
=====================================

ALU_WIDE_SEQUENCER -- requirements
Module: alu_wide_sequencer

Interface
REQ-001 SHALL have parameter: W, 4, ALU word width in bits (matches the attached alu).
REQ-002 SHALL have parameter: K, 4, number of W-bit words per operand (K>=2); operand width is K*W.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: req_valid  input  1  request present.
REQ-006 SHALL have port: req_ready  output  1  sequencer can accept a request.
REQ-007 SHALL have port: req_op  input  1  0 = add, 1 = subtract.
REQ-008 SHALL have port: req_a  input  K*W  wide operand A.
REQ-009 SHALL have port: req_b  input  K*W  wide operand B.
REQ-010 SHALL have port: req_cin  input  1  carry into least-significant word.
REQ-011 SHALL have port: alu_opcode  output  W  opcode to alu (alu_ops::ADD_OP or alu_ops::SUB_OP).
REQ-012 SHALL have ports: alu_a, alu_b  output  W  current word operands to alu.
REQ-013 SHALL have port: alu_c_in  output  1  carry to alu for current word.
REQ-014 SHALL have ports: alu_y  input  W; alu_c_out, alu_v, alu_n, alu_z  input  1  combinational alu result and flags for current word.
REQ-015 SHALL have port: rsp_valid  output  1  result present.
REQ-016 SHALL have port: rsp_ready  input  1  consumer accepts result.
REQ-017 SHALL have port: rsp_y  output  K*W  wide result.
REQ-018 SHALL have ports: rsp_c, rsp_v, rsp_n, rsp_z  output  1  wide carry, overflow, negative, zero.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DONE.
REQ-020 SHALL drive req_ready = 1 only in IDLE; rsp_valid = 1 only in DONE.
REQ-021 IDLE: on req_valid && req_ready, SHALL register req_a, req_b, req_op, req_cin; clear word index to 0; clear zero accumulator to 1; go to RUN.
REQ-022 RUN: SHALL drive alu_a/alu_b = word[idx] of registered A/B (idx 0 = bits W-1:0); alu_c_in = req_cin for idx 0, else registered alu_c_out of previous word.
REQ-023 RUN: alu_opcode SHALL be alu_ops::SUB_OP when req_op = 1, else alu_ops::ADD_OP.
REQ-024 RUN: each cycle SHALL write alu_y into rsp_y word[idx], register alu_c_out as carry, AND alu_z into zero accumulator, increment idx.
REQ-025 RUN: on idx = K-1 SHALL additionally latch rsp_c = alu_c_out, rsp_v = alu_v, rsp_n = alu_n, rsp_z = accumulator AND alu_z, and go to DONE.
REQ-026 Latency: accept at edge T -> rsp_valid high from edge T+K; RUN lasts exactly K cycles; no stall inside RUN.
REQ-027 DONE: rsp_y and flags SHALL hold stable until rsp_valid && rsp_ready, then go to IDLE; a new request is accepted no earlier than the following cycle.
REQ-028 Subtract convention: the attached alu SUB_OP computes a + ~b + c_in with c_out = carry (carry = not-borrow); a plain wide subtract therefore uses req_cin = 1.
REQ-029 Outside RUN, alu_a, alu_b, alu_c_in SHALL be 0 and alu_opcode SHALL be alu_ops::ADD_OP.
REQ-030 req_valid in RUN or DONE SHALL be ignored (not accepted, not lost by the sequencer; the requester holds it).
REQ-031 Index SHALL be wide enough for K-1 and SHALL NOT wrap within an operation.

Reset
REQ-032 With rst = 1 at an edge: state = IDLE, idx = 0, carry = 0, rsp_y = 0, rsp_c/v/n/z = 0, rsp_valid = 0, req_ready = 1 after that edge.
REQ-033 Reset in RUN or DONE SHALL abort the operation with no response; rst has priority over all handshakes in the same cycle.

Verification (W=4, K=4, reference alu model per REQ-028)
REQ-034 add 0x00FF + 0x0001, cin=0 -> rsp_y=0x0100, c=0, v=0, n=0, z=0, rsp_valid 4 cycles after accept.
REQ-035 add 0xFFFF + 0x0001, cin=0 -> rsp_y=0x0000, c=1, v=0, n=0, z=1 (carry rippled through all 4 words).
REQ-036 add 0x7FFF + 0x0001 -> rsp_y=0x8000, v=1, n=1, c=0, z=0; sub 0x0005 - 0x0005, cin=1 -> 0x0000, c=1, z=1.
REQ-037 rsp_ready held low 3 cycles in DONE -> rsp_y/flags stable, req_ready=0 and a concurrent req_valid not accepted; accepted the cycle after rsp_ready handshake.
REQ-038 rst asserted on 2nd RUN cycle -> next cycle IDLE, req_ready=1, rsp_valid=0, all rsp outputs 0; following request completes correctly.

Source files
------------

// File: rtl/alu_wide_sequencer.sv
// Wide add/subtract sequencer: drives one external W-bit alu a word per cycle,
// rippling the carry, and assembles a K*W-bit result with wide flags.
package alu_ops;
    localparam int ADD_OP = 0;
    localparam int SUB_OP = 1;
endpackage

module alu_wide_sequencer #(
    parameter int W = 4,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_op,
    input  logic [K*W-1:0] req_a,
    input  logic [K*W-1:0] req_b,
    input  logic           req_cin,
    output logic [W-1:0]   alu_opcode,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic           alu_c_in,
    input  logic [W-1:0]   alu_y,
    input  logic           alu_c_out,
    input  logic           alu_v,
    input  logic           alu_n,
    input  logic           alu_z,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [K*W-1:0] rsp_y,
    output logic           rsp_c,
    output logic           rsp_v,
    output logic           rsp_n,
    output logic           rsp_z
);

    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_reg;
    logic [IW-1:0]  idx_reg;
    logic [K*W-1:0] a_reg;
    logic [K*W-1:0] b_reg;
    logic           op_reg;
    logic           cin_reg;
    logic           carry_reg;
    logic           zacc_reg;
    logic           rsp_c_reg;
    logic           rsp_v_reg;
    logic           rsp_n_reg;
    logic           rsp_z_reg;
    logic [W-1:0]   rsp_words_reg [K];
    logic [W-1:0]   a_words [K];
    logic [W-1:0]   b_words [K];
    logic           last_word;

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_words
            assign a_words[gi]          = a_reg[gi*W +: W];
            assign b_words[gi]          = b_reg[gi*W +: W];
            assign rsp_y[gi*W +: W]     = rsp_words_reg[gi];
        end
    endgenerate

    assign last_word = (idx_reg == IW'(K - 1));
    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == DONE);
    assign rsp_c     = rsp_c_reg;
    assign rsp_v     = rsp_v_reg;
    assign rsp_n     = rsp_n_reg;
    assign rsp_z     = rsp_z_reg;

    // The alu port is quiet (zero operands, ADD) whenever no word is in flight.
    always_comb begin
        alu_opcode = W'(alu_ops::ADD_OP);
        alu_a      = '0;
        alu_b      = '0;
        alu_c_in   = 1'b0;
        if (state_reg == RUN) begin
            alu_opcode = op_reg ? W'(alu_ops::SUB_OP) : W'(alu_ops::ADD_OP);
            alu_a      = a_words[idx_reg];
            alu_b      = b_words[idx_reg];
            alu_c_in   = (idx_reg == '0) ? cin_reg : carry_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= 1'b0;
            cin_reg   <= 1'b0;
            carry_reg <= 1'b0;
            zacc_reg  <= 1'b1;
            rsp_c_reg <= 1'b0;
            rsp_v_reg <= 1'b0;
            rsp_n_reg <= 1'b0;
            rsp_z_reg <= 1'b0;
            for (int i = 0; i < K; i++) begin
                rsp_words_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        a_reg     <= req_a;
                        b_reg     <= req_b;
                        op_reg    <= req_op;
                        cin_reg   <= req_cin;
                        idx_reg   <= '0;
                        zacc_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    rsp_words_reg[idx_reg] <= alu_y;
                    carry_reg              <= alu_c_out;
                    zacc_reg               <= zacc_reg & alu_z;
                    if (last_word) begin
                        // Sign and overflow come from the top word only.
                        rsp_c_reg <= alu_c_out;
                        rsp_v_reg <= alu_v;
                        rsp_n_reg <= alu_n;
                        rsp_z_reg <= zacc_reg & alu_z;
                        idx_reg   <= '0;
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed bench for alu_wide_sequencer (W=4, K=4) with a behavioural 4-bit alu
// attached; each check is an immediate assertion against a hand-computed value.
module tb_alu_wide_sequencer;
    localparam int W = 4;
    localparam int K = 4;

    logic           clk;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic           req_op;
    logic [K*W-1:0] req_a;
    logic [K*W-1:0] req_b;
    logic           req_cin;
    logic [W-1:0]   alu_opcode;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic           alu_c_in;
    logic [W-1:0]   alu_y;
    logic           alu_c_out;
    logic           alu_v;
    logic           alu_n;
    logic           alu_z;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [K*W-1:0] rsp_y;
    logic           rsp_c;
    logic           rsp_v;
    logic           rsp_n;
    logic           rsp_z;

    int n_cmp;
    int n_err;

    alu_wide_sequencer #(.W(W), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .alu_opcode(alu_opcode),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c_in  (alu_c_in),
        .alu_y     (alu_y),
        .alu_c_out (alu_c_out),
        .alu_v     (alu_v),
        .alu_n     (alu_n),
        .alu_z     (alu_z),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_c     (rsp_c),
        .rsp_v     (rsp_v),
        .rsp_n     (rsp_n),
        .rsp_z     (rsp_z)
    );

    // Reference alu: SUB computes a + ~b + c_in, carry out is not-borrow.
    logic [W-1:0] eff_b;
    logic [W:0]   sum;
    always_comb begin
        eff_b     = (alu_opcode == W'(alu_ops::SUB_OP)) ? ~alu_b : alu_b;
        sum       = {1'b0, alu_a} + {1'b0, eff_b} + {{W{1'b0}}, alu_c_in};
        alu_y     = sum[W-1:0];
        alu_c_out = sum[W];
        alu_n     = sum[W-1];
        alu_z     = (sum[W-1:0] == '0);
        alu_v     = (alu_a[W-1] == eff_b[W-1]) && (sum[W-1] != alu_a[W-1]);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request and take it at the next edge; checks the first RUN word.
    task automatic issue(input logic op, input logic [15:0] a, input logic [15:0] b, input logic cin);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("accept_ready_low", req_ready, 1'b0);
        check("run_alu_a0", alu_a, a[3:0]);
        check("run_alu_b0", alu_b, b[3:0]);
        check("run_alu_cin0", alu_c_in, cin);
        check("run_opcode", alu_opcode, op ? W'(alu_ops::SUB_OP) : W'(alu_ops::ADD_OP));
    endtask

    // rsp_valid must rise exactly K edges after the accepting edge.
    task automatic wait_rsp();
        for (int i = 1; i <= K; i++) begin
            step();
            check($sformatf("latency_cyc%0d", i), rsp_valid, (i == K) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic check_rsp(input string tag, input logic [15:0] y, input logic c,
                             input logic v, input logic n, input logic z);
        check({tag, "_y"}, rsp_y, y);
        check({tag, "_c"}, rsp_c, c);
        check({tag, "_v"}, rsp_v, v);
        check({tag, "_n"}, rsp_n, n);
        check({tag, "_z"}, rsp_z, z);
        check({tag, "_alu_idle"}, {alu_opcode, alu_a, alu_b, alu_c_in}, 32'h0);
        $display("txn %s: rsp_y=0x%04h c=%0b v=%0b n=%0b z=%0b", tag, rsp_y, rsp_c, rsp_v, rsp_n, rsp_z);
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("release_req_ready", req_ready, 1'b1);
        check("release_rsp_valid", rsp_valid, 1'b0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = 1'b0;
        rsp_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_y", rsp_y, 16'h0000);
        check("reset_flags", {rsp_c, rsp_v, rsp_n, rsp_z}, 4'h0);
        check("reset_alu_idle", {alu_opcode, alu_a, alu_b, alu_c_in}, 32'h0);

        issue(1'b0, 16'h00FF, 16'h0001, 1'b0);
        wait_rsp();
        check_rsp("add_00ff_1", 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        release_rsp();

        issue(1'b0, 16'hFFFF, 16'h0001, 1'b0);
        wait_rsp();
        check_rsp("add_ffff_1", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        release_rsp();

        issue(1'b0, 16'h7FFF, 16'h0001, 1'b0);
        wait_rsp();
        check_rsp("add_7fff_1", 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);
        release_rsp();

        issue(1'b1, 16'h0005, 16'h0005, 1'b1);
        wait_rsp();
        check_rsp("sub_5_5", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        release_rsp();

        issue(1'b1, 16'h0000, 16'h0001, 1'b1);
        wait_rsp();
        check_rsp("sub_0_1", 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        release_rsp();

        // Backpressure in DONE with a competing request held by the requester.
        issue(1'b0, 16'h1234, 16'h1111, 1'b0);
        wait_rsp();
        req_op    = 1'b0;
        req_a     = 16'h0002;
        req_b     = 16'h0003;
        req_cin   = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall%0d_valid", i), rsp_valid, 1'b1);
            check($sformatf("stall%0d_ready", i), req_ready, 1'b0);
            check($sformatf("stall%0d_y", i), rsp_y, 16'h2345);
            check($sformatf("stall%0d_flags", i), {rsp_c, rsp_v, rsp_n, rsp_z}, 4'h0);
        end
        $display("txn stall: rsp_y=0x%04h held 3 cycles", rsp_y);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("handshake_req_ready", req_ready, 1'b1);
        check("handshake_rsp_valid", rsp_valid, 1'b0);
        step();
        req_valid = 1'b0;
        check("held_req_accepted", req_ready, 1'b0);
        check("held_req_alu_a0", alu_a, 4'h2);
        wait_rsp();
        check_rsp("add_2_3", 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
        release_rsp();

        // Reset on the second RUN cycle aborts with no response.
        issue(1'b0, 16'h1111, 16'h2222, 1'b0);
        check("abort_rsp_valid_run", rsp_valid, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_req_ready", req_ready, 1'b1);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        check("abort_rsp_y", rsp_y, 16'h0000);
        check("abort_flags", {rsp_c, rsp_v, rsp_n, rsp_z}, 4'h0);
        check("abort_alu_idle", {alu_opcode, alu_a, alu_b, alu_c_in}, 32'h0);
        $display("txn abort: req_ready=%0b rsp_valid=%0b rsp_y=0x%04h", req_ready, rsp_valid, rsp_y);

        issue(1'b1, 16'h1000, 16'h0001, 1'b1);
        wait_rsp();
        check_rsp("sub_1000_1", 16'h0FFF, 1'b1, 1'b0, 1'b0, 1'b0);
        release_rsp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
